// File: rtl/palette_pkg.sv
// Shared types and constants for the sprite palette lookup.
package palette_pkg;
  localparam int PAL_CH_W = 4;

  typedef struct packed {
    logic [PAL_CH_W-1:0] red;
    logic [PAL_CH_W-1:0] green;
    logic [PAL_CH_W-1:0] blue;
  } rgb_t;

  localparam rgb_t PAL_DEFAULT_RGB = '{red: 4'h6, green: 4'hA, blue: 4'hF};

  // Bank select needs at least one bit even for a single palette.
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette store: one write port, one registered read port.
module palette_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Kept free of reset so it maps onto block RAM; same-address reads see the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/palette_lut.sv
// Multi-bank runtime-writable palette: index -> 12-bit RGB in two register stages,
// with a transparency key and frame-synchronous colour cycling over an index range.
module palette_lut import palette_pkg::*; #(
  parameter int               INDEX_W      = 4,
  parameter int               NUM_BANKS    = 4,
  parameter int               CH_W         = PAL_CH_W,
  parameter logic [3*CH_W-1:0] DEFAULT_RGB = PAL_DEFAULT_RGB,
  parameter int               TRANSP_INDEX = 1,
  parameter int               CYC_LO       = 8,
  parameter int               CYC_HI       = 11,
  parameter int               CYC_PERIOD   = 8,
  localparam int              BANK_W       = bank_w(NUM_BANKS)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                in_valid,
  input  logic [BANK_W-1:0]   in_bank,
  input  logic [INDEX_W-1:0]  in_index,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_red,
  output logic [CH_W-1:0]     out_green,
  output logic [CH_W-1:0]     out_blue,
  output logic                out_transp,
  input  logic                wr_en,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0]   wr_rgb,
  input  logic                frame_tick,
  input  logic                cyc_en,
  output logic                init_busy
);
  localparam int DEPTH = NUM_BANKS << INDEX_W;
  localparam int AW    = BANK_W + INDEX_W;
  localparam int CYC_N = CYC_HI - CYC_LO + 1;
  localparam int FC_W  = (CYC_PERIOD > 1) ? $clog2(CYC_PERIOD) : 1;
  localparam int DW    = 3 * CH_W;

  logic                busy_q, busy_d;
  logic [AW-1:0]       sweep_q, sweep_d;
  logic [FC_W-1:0]     fc_q, fc_d;
  logic [INDEX_W-1:0]  off_q, off_d;
  logic [1:0]          vld_pipe_q, vld_pipe_d;
  logic [AW-1:0]       s1_addr_q, s1_addr_d;
  logic                s1_ok_q, s1_ok_d, s1_transp_q, s1_transp_d;
  logic                s2_ok_q, s2_ok_d, s2_transp_q, s2_transp_d;
  logic                wr_vld_q, wr_vld_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DW-1:0]       wr_data_q, wr_data_d;
  logic [INDEX_W:0]    rel;
  logic [INDEX_W-1:0]  eff_idx;
  logic [DW-1:0]       ram_rd;

  always_comb begin
    busy_d  = busy_q;
    sweep_d = sweep_q;
    if (busy_q) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == AW'(DEPTH - 1)) busy_d = 1'b0;
    end

    fc_d  = fc_q;
    off_d = off_q;
    if (cyc_en && frame_tick) begin
      if (fc_q == FC_W'(CYC_PERIOD - 1)) begin
        fc_d  = '0;
        off_d = (off_q == INDEX_W'(CYC_N - 1)) ? '0 : off_q + 1'b1;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end

    // Rotate indices inside the cycling window; both terms are < N so one subtract wraps.
    rel     = '0;
    eff_idx = in_index;
    if (32'(in_index) >= CYC_LO && 32'(in_index) <= CYC_HI) begin
      rel = {1'b0, in_index} - (INDEX_W+1)'(CYC_LO) + {1'b0, off_q};
      if (rel >= (INDEX_W+1)'(CYC_N)) rel = rel - (INDEX_W+1)'(CYC_N);
      eff_idx = INDEX_W'(rel) + INDEX_W'(CYC_LO);
    end

    vld_pipe_d  = {vld_pipe_q[0], in_valid && !busy_q};
    s1_ok_d     = 32'(in_bank) < NUM_BANKS;
    s1_addr_d   = s1_ok_d ? {in_bank, eff_idx} : '0;
    s1_transp_d = (in_index == INDEX_W'(TRANSP_INDEX));

    s2_ok_d     = s2_ok_q;
    s2_transp_d = s2_transp_q;
    if (vld_pipe_q[0]) begin
      s2_ok_d     = s1_ok_q;
      s2_transp_d = s1_transp_q;
    end

    // Host writes are staged one cycle so they line up with the RAM read of a same-cycle lookup.
    wr_vld_d  = wr_en && !busy_q && (32'(wr_bank) < NUM_BANKS);
    wr_addr_d = {wr_bank, wr_index};
    wr_data_d = wr_rgb;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      busy_q      <= 1'b1;
      sweep_q     <= '0;
      fc_q        <= '0;
      off_q       <= '0;
      vld_pipe_q  <= '0;
      s1_addr_q   <= '0;
      s1_ok_q     <= 1'b0;
      s1_transp_q <= 1'b0;
      s2_ok_q     <= 1'b0;
      s2_transp_q <= 1'b0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      sweep_q     <= sweep_d;
      fc_q        <= fc_d;
      off_q       <= off_d;
      vld_pipe_q  <= vld_pipe_d;
      s1_addr_q   <= s1_addr_d;
      s1_ok_q     <= s1_ok_d;
      s1_transp_q <= s1_transp_d;
      s2_ok_q     <= s2_ok_d;
      s2_transp_q <= s2_transp_d;
      wr_vld_q    <= wr_vld_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  palette_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
    .clk   (Clk),
    .rst_n (Reset_n),
    .we    (Reset_n && (busy_q || wr_vld_q)),
    .waddr (busy_q ? sweep_q : wr_addr_q),
    .wdata (busy_q ? DEFAULT_RGB : wr_data_q),
    .re    (vld_pipe_q[0]),
    .raddr (s1_addr_q),
    .rdata (ram_rd)
  );

  assign out_valid  = vld_pipe_q[1];
  assign {out_red, out_green, out_blue} = s2_ok_q ? ram_rd : '0;
  assign out_transp = s2_transp_q;
  assign init_busy  = busy_q;
endmodule

// File: tb/tb_palette_lut.sv
// Bench for palette_lut: table-driven lookups plus sequences for sweep, collision and cycling.
module tb_palette_lut;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_bank = '0;
  logic [3:0]  in_index = '0;
  logic        out_valid;
  logic [3:0]  out_red, out_green, out_blue;
  logic        out_transp;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = '0;
  logic [3:0]  wr_index = '0;
  logic [11:0] wr_rgb = '0;
  logic        frame_tick = 1'b0;
  logic        cyc_en = 1'b0;
  logic        init_busy;

  palette_lut dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_bank(in_bank), .in_index(in_index),
    .out_valid(out_valid), .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
    .out_transp(out_transp), .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index),
    .wr_rgb(wr_rgb), .frame_tick(frame_tick), .cyc_en(cyc_en), .init_busy(init_busy)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [11:0] rgb; logic tr; int cyc; } exp_t;
  typedef struct { logic [1:0] bank; logic [3:0] idx; logic [11:0] rgb; logic tr; } vec_t;

  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0;
  logic [11:0] model [64];
  int          off_m = 0, tick_m = 0;
  bit          ready = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Reset_n && out_valid === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_valid: out_valid=1 at cycle %0d, required no output", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({out_red, out_green, out_blue} !== e.rgb || out_transp !== e.tr || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL lookup: got rgb=%h transp=%b cycle=%0d, required rgb=%h transp=%b cycle=%0d",
                   {out_red, out_green, out_blue}, out_transp, cyc, e.rgb, e.tr, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input logic [1:0] b, input logic [3:0] i);
    int e;
    e = int'(i);
    if (e >= 8 && e <= 11) e = 8 + ((e - 8 + off_m) % 4);
    return model[int'(b) * 16 + e];
  endfunction

  // Drive one cycle; the bench models update after any expectation for this cycle was pushed.
  task automatic drive(input logic v, input logic [1:0] b, input logic [3:0] i,
                       input logic we, input logic [1:0] wb, input logic [3:0] wi,
                       input logic [11:0] wd, input logic tick, input logic cen);
    in_valid = v; in_bank = b; in_index = i;
    wr_en = we; wr_bank = wb; wr_index = wi; wr_rgb = wd;
    frame_tick = tick; cyc_en = cen;
    if (ready && we) model[int'(wb) * 16 + int'(wi)] = wd;
    if (ready && tick && cen) begin
      tick_m++;
      if (tick_m % 8 == 0) off_m = (off_m + 1) % 4;
    end
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic look(input logic [1:0] b, input logic [3:0] i);
    if (ready) sb.push_back('{exp_rgb(b, i), (i == 4'd1), cyc + 2});
    drive(1, b, i, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [1:0] b, input logic [3:0] i, input logic [11:0] d);
    drive(0, 0, 0, 1, b, i, d, 0, 0);
  endtask

  // Runs the sweep to completion (with ignored traffic) and checks its length.
  task automatic sweep_wait(input string name);
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < 200) begin
      drive(1, 2'd0, 4'd4, 1, 2'd0, 4'd4, 12'h999, 0, 0);
      n++;
    end
    check(name, n, 64);
    ready = 1;
    off_m = 0; tick_m = 0;
    for (int k = 0; k < 64; k++) model[k] = 12'h6AF;
  endtask

  task automatic reset_check(input string name);
    ready = 0;
    Reset_n = 0;
    idle(2);
    check({name, "_valid"}, out_valid, 0);
    check({name, "_rgb"}, {out_red, out_green, out_blue}, 0);
    check({name, "_transp"}, out_transp, 0);
    check({name, "_busy"}, init_busy, 1);
    Reset_n = 1;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{2'd0, 4'd3,  12'h520, 1'b0};
    tbl[1] = '{2'd1, 4'd3,  12'h6AF, 1'b0};
    tbl[2] = '{2'd2, 4'd5,  12'h6AF, 1'b0};
    tbl[3] = '{2'd0, 4'd1,  12'h6AF, 1'b1};
    tbl[4] = '{2'd0, 4'd0,  12'h6AF, 1'b0};
    tbl[5] = '{2'd1, 4'd7,  12'h0F0, 1'b0};
    tbl[6] = '{2'd2, 4'd0,  12'h123, 1'b0};
    tbl[7] = '{2'd3, 4'd1,  12'h6AF, 1'b1};
    tbl[8] = '{2'd3, 4'd15, 12'hABC, 1'b0};

    reset_check("reset");
    sweep_wait("sweep_len");

    // First lookup after the sweep, then a write immediately followed by its lookup.
    sb.push_back('{12'h6AF, 1'b0, cyc + 2});
    drive(1, 2'd2, 4'd5, 0, 0, 0, 0, 0, 0);
    wr(2'd0, 4'd3, 12'h520);
    sb.push_back('{12'h520, 1'b0, cyc + 2});
    drive(1, 2'd0, 4'd3, 0, 0, 0, 0, 0, 0);
    wr(2'd1, 4'd7, 12'h0F0);
    wr(2'd3, 4'd15, 12'hABC);
    wr(2'd2, 4'd0, 12'h123);

    // Back-to-back table lookups: continuous valid, order and latency checked by the monitor.
    for (int k = 0; k < 9; k++) begin
      sb.push_back('{tbl[k].rgb, tbl[k].tr, cyc + 2});
      drive(1, tbl[k].bank, tbl[k].idx, 0, 0, 0, 0, 0, 0);
    end
    idle(4);
    check("idle_valid", out_valid, 0);
    check("idle_hold_rgb", {out_red, out_green, out_blue}, 12'hABC);
    check("sb_drain_1", sb.size(), 0);

    // Same-cycle write and lookup of one entry: old colour, then new.
    look(2'd0, 4'd4);
    check("collide_model_old", exp_rgb(2'd0, 4'd4), 12'h6AF);
    sb.push_back('{12'h6AF, 1'b0, cyc + 2});
    drive(1, 2'd0, 4'd4, 1, 2'd0, 4'd4, 12'hDEF, 0, 0);
    sb.push_back('{12'hDEF, 1'b0, cyc + 2});
    drive(1, 2'd0, 4'd4, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Colour cycling over indices 8..11.
    wr(2'd0, 4'd8,  12'h111);
    wr(2'd0, 4'd9,  12'h222);
    wr(2'd0, 4'd10, 12'h333);
    wr(2'd0, 4'd11, 12'h444);
    wr(2'd0, 4'd12, 12'h555);
    look(2'd0, 4'd8);
    look(2'd0, 4'd12);
    for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    sb.push_back('{12'h222, 1'b0, cyc + 2});
    drive(1, 2'd0, 4'd8, 0, 0, 0, 0, 0, 1);
    sb.push_back('{12'h111, 1'b0, cyc + 2});
    drive(1, 2'd0, 4'd11, 0, 0, 0, 0, 0, 1);
    look(2'd0, 4'd12);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    sb.push_back('{12'h222, 1'b0, cyc + 2});
    drive(1, 2'd0, 4'd8, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 24; k++) drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    sb.push_back('{12'h111, 1'b0, cyc + 2});
    drive(1, 2'd0, 4'd8, 0, 0, 0, 0, 0, 1);
    sb.push_back('{12'h555, 1'b0, cyc + 2});
    drive(1, 2'd0, 4'd12, 0, 0, 0, 0, 0, 1);
    look(2'd0, 4'd10);
    idle(4);
    check("sb_drain_2", sb.size(), 0);

    // Reset reasserted mid-sweep restarts it; writes and lookups during the sweep are ignored.
    reset_check("reset2");
    for (int k = 0; k < 30; k++) drive(1, 2'd1, 4'd3, 1, 2'd0, 4'd4, 12'h999, 0, 0);
    Reset_n = 0;
    idle(1);
    check("restart_busy", init_busy, 1);
    Reset_n = 1;
    sweep_wait("restart_sweep_len");
    sb.push_back('{12'h6AF, 1'b0, cyc + 2});
    drive(1, 2'd0, 4'd4, 0, 0, 0, 0, 0, 0);
    sb.push_back('{12'h6AF, 1'b0, cyc + 2});
    drive(1, 2'd0, 4'd3, 0, 0, 0, 0, 0, 0);
    sb.push_back('{12'h6AF, 1'b0, cyc + 2});
    drive(1, 2'd0, 4'd8, 0, 0, 0, 0, 0, 0);
    idle(4);
    check("sb_drain_3", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end
endmodule
